// File: rtl/enemy_bullet_ctrl.sv
// Enemy bullet controller: spawns, moves and retires
// the single enemy bullet fed to the collision judge.
module enemy_bullet_ctrl #(
  parameter int SCREEN_H      = 480,
  parameter int STEP          = 4,
  parameter int FIRE_INTERVAL = 60,
  parameter int X_OFF         = 20,
  parameter int Y_OFF         = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enemy_en,
  input  logic [9:0] e_x,
  input  logic [9:0] e_y,
  input  logic       hit,
  output logic [9:0] eb_x,
  output logic [9:0] eb_y,
  output logic       enemy_bullet_en,
  output logic [7:0] shot_count
);

  localparam int CW =
    (FIRE_INTERVAL > 1) ? $clog2(FIRE_INTERVAL) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(FIRE_INTERVAL - 1);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    FLY  = 2'd1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          en_q, en_d;
  logic [7:0]    shots_q, shots_d;
  logic [10:0]   ny;

  // State and output registers, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
      shots_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
      shots_q <= shots_d;
    end
  end

  // Next-state: interval count, spawn, move, retire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    en_d    = en_q;
    shots_d = shots_q;
    ny      = {1'b0, y_q} + 11'(STEP);
    case (state_q)
      WAIT: begin
        en_d = 1'b0;
        if (!enemy_en) begin
          cnt_d = '0;
        end else if (frame_tick) begin
          if (cnt_q >= LAST) begin
            x_d     = e_x + 10'(X_OFF);
            y_d     = e_y + 10'(Y_OFF);
            en_d    = 1'b1;
            shots_d = shots_q + 8'd1;
            cnt_d   = '0;
            state_d = FLY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLY: begin
        en_d = 1'b1;
        if (hit) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end else if (frame_tick) begin
          if (ny >= 11'(SCREEN_H)) begin
            en_d    = 1'b0;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            y_d = ny[9:0];
          end
        end
      end
      default: begin
        en_d    = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
    endcase
  end

  assign eb_x            = x_q;
  assign eb_y            = y_q;
  assign enemy_bullet_en = en_q;
  assign shot_count      = shots_q;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Bench for enemy_bullet_ctrl: directed scenarios
// plus random traffic against a behavioural model.
module tb_enemy_bullet_ctrl;

  localparam int H  = 480;
  localparam int ST = 4;
  localparam int FI = 60;
  localparam int XO = 20;
  localparam int YO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enemy_en = 1'b0;
  logic [9:0] e_x = '0;
  logic [9:0] e_y = '0;
  logic       hit = 1'b0;
  logic [9:0] eb_x, eb_y;
  logic       enemy_bullet_en;
  logic [7:0] shot_count;

  int n_cmp = 0;
  int n_bad = 0;

  enemy_bullet_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .enemy_en        (enemy_en),
    .e_x             (e_x),
    .e_y             (e_y),
    .hit             (hit),
    .eb_x            (eb_x),
    .eb_y            (eb_y),
    .enemy_bullet_en (enemy_bullet_en),
    .shot_count      (shot_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: bullet record plus ticks since retirement.
  bit m_live;
  int m_x, m_y, m_shots, m_ticks;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_live  <= 1'b0;
      m_x     <= 0;
      m_y     <= 0;
      m_shots <= 0;
      m_ticks <= 0;
    end else if (m_live) begin
      if (hit) begin
        m_live  <= 1'b0;
        m_ticks <= 0;
      end else if (frame_tick) begin
        if (m_y + ST >= H) begin
          m_live  <= 1'b0;
          m_ticks <= 0;
        end else begin
          m_y <= m_y + ST;
        end
      end
    end else if (!enemy_en) begin
      m_ticks <= 0;
    end else if (frame_tick) begin
      if (m_ticks + 1 == FI) begin
        m_live  <= 1'b1;
        m_x     <= (int'(e_x) + XO) % 1024;
        m_y     <= (int'(e_y) + YO) % 1024;
        m_shots <= (m_shots + 1) % 256;
        m_ticks <= 0;
      end else begin
        m_ticks <= m_ticks + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  bit cmp_on = 1'b0;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst && cmp_on) begin
      chk("model_en", int'(enemy_bullet_en), int'(m_live));
      chk("model_shots", int'(shot_count), m_shots);
      if (m_live) begin
        chk("model_x", int'(eb_x), m_x);
        chk("model_y", int'(eb_y), m_y);
      end
    end
  end

  task automatic cyc(input bit ft, input bit h);
    frame_tick = ft;
    hit        = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hit        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", int'(enemy_bullet_en), 0);
    chk("reset_shots", int'(shot_count), 0);
    chk("reset_y", int'(eb_y), 0);
    e_x = 10'd100;
    e_y = 10'd50;
    enemy_en = 1'b1;
    rst = 1'b1;
    cmp_on = 1'b1;
    cyc(1'b0, 1'b0);

    // Spawn after exactly 60 ticks.
    ticks(59);
    chk("no_early_spawn", int'(enemy_bullet_en), 0);
    ticks(1);
    chk("spawn_en", int'(enemy_bullet_en), 1);
    chk("spawn_x", int'(eb_x), 120);
    chk("spawn_y", int'(eb_y), 90);
    chk("spawn_shots", int'(shot_count), 1);

    // Flight to the bottom edge and exit.
    ticks(97);
    chk("fly_y478", int'(eb_y), 478);
    chk("fly_en", int'(enemy_bullet_en), 1);
    chk("fly_x", int'(eb_x), 120);
    ticks(1);
    chk("exit_en", int'(enemy_bullet_en), 0);
    chk("exit_y", int'(eb_y), 478);
    ticks(59);
    chk("respawn_early", int'(enemy_bullet_en), 0);
    ticks(1);
    chk("respawn_en", int'(enemy_bullet_en), 1);
    chk("respawn_shots", int'(shot_count), 2);

    // Hit wins over tick; hit in WAIT is ignored.
    cyc(1'b0, 1'b1);
    chk("hit_en", int'(enemy_bullet_en), 0);
    chk("hit_y", int'(eb_y), 90);
    e_y = 10'd0;
    ticks(60);
    chk("spawn3_y", int'(eb_y), 40);
    ticks(40);
    chk("at200", int'(eb_y), 200);
    cyc(1'b1, 1'b1);
    chk("hit_tick_en", int'(enemy_bullet_en), 0);
    chk("hit_tick_y", int'(eb_y), 200);
    ticks(10);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("wait_hit_en", int'(enemy_bullet_en), 0);
    chk("wait_hit_y", int'(eb_y), 200);
    chk("wait_hit_shots", int'(shot_count), 3);
    ticks(48);
    chk("wait_hit_early", int'(enemy_bullet_en), 0);
    ticks(1);
    chk("wait_hit_spawn", int'(enemy_bullet_en), 1);
    chk("wait_hit_shots4", int'(shot_count), 4);

    // Enemy gating clears the interval count.
    cyc(1'b0, 1'b1);
    ticks(20);
    enemy_en = 1'b0;
    ticks(30);
    chk("gated_en", int'(enemy_bullet_en), 0);
    enemy_en = 1'b1;
    ticks(59);
    chk("gated_early", int'(enemy_bullet_en), 0);
    ticks(1);
    chk("gated_spawn", int'(enemy_bullet_en), 1);
    chk("gated_shots", int'(shot_count), 5);
    enemy_en = 1'b0;
    ticks(5);
    chk("drop_mid_en", int'(enemy_bullet_en), 1);
    chk("drop_mid_y", int'(eb_y), 60);

    // Asynchronous reset in flight.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_en", int'(enemy_bullet_en), 0);
    chk("async_x", int'(eb_x), 0);
    chk("async_y", int'(eb_y), 0);
    chk("async_shots", int'(shot_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    enemy_en = 1'b1;
    ticks(59);
    chk("post_rst_early", int'(enemy_bullet_en), 0);
    ticks(1);
    chk("post_rst_spawn", int'(shot_count), 1);

    // Truncated spawn coordinates.
    cyc(1'b0, 1'b1);
    e_x = 10'd1010;
    e_y = 10'd1000;
    ticks(60);
    chk("trunc_x", int'(eb_x), 6);
    chk("trunc_y", int'(eb_y), 16);
    chk("trunc_shots", int'(shot_count), 2);
    ticks(1);
    chk("trunc_exit", int'(enemy_bullet_en), 1);

    // Shot counter wraps after 256 shots.
    e_x = 10'd5;
    e_y = 10'd5;
    for (int s = 0; s < 254; s++) begin
      cyc(1'b0, 1'b1);
      ticks(60);
    end
    chk("wrap_shots", int'(shot_count), 0);
    chk("wrap_en", int'(enemy_bullet_en), 1);

    // Random traffic, checked by the model each cycle.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 199) == 0)
        enemy_en = ~enemy_en;
      if ($urandom_range(0, 3) == 0) begin
        e_x = 10'($urandom);
        e_y = 10'($urandom_range(0, 1023));
      end
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0));
    end

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
